// File: rtl/multi_mode_tick_divider.sv
// Purpose: divides `clock` into a one-cycle tick and a near-50% square wave, divisor picked from three presets or a loadable custom value.
// Latency: outputs are registered; a mode or divisor change takes effect at the next period boundary (immediately when leaving idle).
// Backpressure: none; enable=0 freezes all period state and forces tick low, while load still updates the custom divisor.
// Ports: clock/reset_n (sync, active-low), enable, sel[1:0], load, div_in[WIDTH-1:0] in;
//        tick, square, count[WIDTH-1:0], active_sel[1:0], tick_count[CNT_W-1:0] out.
module multi_mode_tick_divider #(
    parameter int WIDTH    = 29,
    parameter int CNT_W    = 16,
    parameter int DIV0     = 25000000,
    parameter int DIV1     = 50000000,
    parameter int DIV2     = 100000000,
    parameter int DIV3_RST = 300000000
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             enable,
    input  logic [1:0]       sel,
    input  logic             load,
    input  logic [WIDTH-1:0] div_in,
    output logic             tick,
    output logic             square,
    output logic [WIDTH-1:0] count,
    output logic [1:0]       active_sel,
    output logic [CNT_W-1:0] tick_count
);

    localparam logic [WIDTH-1:0] DIV0_W     = WIDTH'(DIV0);
    localparam logic [WIDTH-1:0] DIV1_W     = WIDTH'(DIV1);
    localparam logic [WIDTH-1:0] DIV2_W     = WIDTH'(DIV2);
    localparam logic [WIDTH-1:0] DIV3_RST_W = WIDTH'(DIV3_RST);

    logic [WIDTH-1:0] cur_div;     // divisor in effect for the current period
    logic [WIDTH-1:0] custom_div;  // runtime-loadable divisor for sel=3

    logic [WIDTH-1:0] sel_div;     // divisor of the requested mode
    logic [WIDTH-1:0] count_inc;
    logic [WIDTH:0]   half_cur;    // ceil(cur_div/2), one extra bit so cur_div=max cannot overflow
    logic             idle;
    logic             at_wrap;
    logic             square_inc;  // square value for count_inc within the current period

    always_comb begin
        sel_div = DIV0_W;
        case (sel)
            2'd0:    sel_div = DIV0_W;
            2'd1:    sel_div = DIV1_W;
            2'd2:    sel_div = DIV2_W;
            default: sel_div = custom_div;
        endcase
    end

    always_comb begin
        idle       = (cur_div == '0);
        // Guarded by !idle so cur_div-1 never relies on underflow.
        at_wrap    = !idle && (count == (cur_div - WIDTH'(1)));
        count_inc  = count + WIDTH'(1);
        half_cur   = ({1'b0, cur_div} + (WIDTH+1)'(1)) >> 1;
        square_inc = ({1'b0, count_inc} < half_cur);
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            count      <= '0;
            tick       <= 1'b0;
            square     <= 1'b0;
            active_sel <= 2'd0;
            cur_div    <= DIV0_W;
            custom_div <= DIV3_RST_W;
            tick_count <= '0;
        end else begin
            if (load) begin
                custom_div <= div_in;
            end
            if (!enable) begin
                tick <= 1'b0;
            end else if (idle || at_wrap) begin
                // Period boundary (or idle): snapshot the requested mode. The new
                // period starts at count 0, where square is high unless the new
                // divisor is 0.
                count      <= '0;
                tick       <= at_wrap;
                active_sel <= sel;
                cur_div    <= sel_div;
                square     <= (sel_div != '0);
                if (at_wrap) begin
                    tick_count <= tick_count + CNT_W'(1);
                end
            end else begin
                count  <= count_inc;
                tick   <= 1'b0;
                square <= square_inc;
            end
        end
    end

endmodule

// File: tb/tb_multi_mode_tick_divider.sv
module tb_multi_mode_tick_divider;

    localparam int WIDTH = 29;
    localparam int CNT_W = 4;

    logic             clock = 1'b0;
    logic             reset_n;
    logic             enable;
    logic [1:0]       sel;
    logic             load;
    logic [WIDTH-1:0] div_in;
    logic             tick;
    logic             square;
    logic [WIDTH-1:0] count;
    logic [1:0]       active_sel;
    logic [CNT_W-1:0] tick_count;

    int total = 0;
    int bad   = 0;

    multi_mode_tick_divider #(
        .WIDTH(WIDTH), .CNT_W(CNT_W),
        .DIV0(4), .DIV1(5), .DIV2(8), .DIV3_RST(3)
    ) dut (
        .clock(clock), .reset_n(reset_n), .enable(enable), .sel(sel),
        .load(load), .div_in(div_in), .tick(tick), .square(square),
        .count(count), .active_sel(active_sel), .tick_count(tick_count)
    );

    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: run did not finish, observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Checks the full output set in one call.
    task automatic chk_all(input string tag, input int c, input bit t, input bit s,
                           input int as, input int tc);
        chk({tag, ".count"},      32'(count),      32'(c));
        chk({tag, ".tick"},       32'(tick),       32'(t));
        chk({tag, ".square"},     32'(square),     32'(s));
        chk({tag, ".active_sel"}, 32'(active_sel), 32'(as));
        chk({tag, ".tick_count"}, 32'(tick_count), 32'(tc));
    endtask

    initial begin
        reset_n = 1'b0; enable = 1'b1; sel = 2'd0; load = 1'b0; div_in = '0;
        step(); step();
        chk_all("reset", 0, 0, 0, 0, 0);

        // Mode 0, period 4: ticks at edges 4, 8, 12; square 1,1,0,0.
        reset_n = 1'b1;
        for (int i = 1; i <= 12; i++) begin
            step();
            chk_all("m0", i % 4, (i % 4) == 0, (i % 4) < 2, 0, i / 4);
        end

        // sel 0->2 at count=1: current period still 4, then period 8.
        step();
        chk("m0to2.count1", 32'(count), 32'd1);
        sel = 2'd2;
        step(); step();
        chk_all("m0to2.pre", 3, 0, 0, 0, 3);
        step();
        chk_all("m0to2.wrap", 0, 1, 1, 2, 4);
        for (int k = 1; k <= 8; k++) begin
            step();
            chk_all("m2", k % 8, k == 8, (k % 8) < 4, 2, (k == 8) ? 5 : 4);
        end

        // Switch to custom mode (reset value 3).
        sel = 2'd3;
        for (int k = 1; k <= 8; k++) step();
        chk_all("m3.enter", 0, 1, 1, 3, 6);
        step();
        chk_all("m3.c1", 1, 0, 1, 3, 6);
        load = 1'b1; div_in = WIDTH'(6);
        step();
        load = 1'b0;
        chk_all("m3.c2", 2, 0, 0, 3, 6);
        step();
        chk_all("m3.wrap3", 0, 1, 1, 3, 7);
        for (int k = 1; k <= 6; k++) begin
            step();
            chk_all("m3p6", (k % 6), k == 6, (k == 6) ? 1'b0 : ((k % 6) < 3), 3, (k == 6) ? 8 : 7);
            if (k == 1) begin
                load = 1'b1; div_in = '0;
            end
            if (k == 2) load = 1'b0;
        end
        // Idle: custom divisor 0 is now in effect.
        step();
        chk_all("idle1", 0, 0, 0, 3, 8);
        step();
        chk_all("idle2", 0, 0, 0, 3, 8);
        sel = 2'd1;
        step();
        chk_all("idle.exit", 0, 0, 1, 1, 8);
        for (int k = 1; k <= 5; k++) begin
            step();
            chk_all("m1", k % 5, k == 5, (k % 5) < 3, 1, (k == 5) ? 9 : 8);
        end

        // Back to mode 0, then freeze at count=2.
        sel = 2'd0;
        for (int k = 1; k <= 5; k++) step();
        chk_all("m1to0.wrap", 0, 1, 1, 0, 10);
        step(); step();
        chk_all("frz.pre", 2, 0, 0, 0, 10);
        enable = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            step();
            chk_all("frz", 2, 0, 0, 0, 10);
        end
        enable = 1'b1;
        step();
        chk_all("frz.post1", 3, 0, 0, 0, 10);
        step();
        chk_all("frz.post2", 0, 1, 1, 0, 11);

        // Enter mode 2, reset mid-period at count=3.
        sel = 2'd2;
        for (int k = 1; k <= 4; k++) step();
        chk_all("m2b.wrap", 0, 1, 1, 2, 12);
        step(); step(); step();
        chk("m2b.count3", 32'(count), 32'd3);
        reset_n = 1'b0;
        step();
        chk_all("midrst", 0, 0, 0, 0, 0);
        reset_n = 1'b1; sel = 2'd0;
        for (int k = 1; k <= 4; k++) begin
            step();
            chk_all("postrst", k % 4, k == 4, (k % 4) < 2, 0, (k == 4) ? 1 : 0);
        end

        // tick_count wraps at 16 ticks.
        for (int k = 1; k <= 60; k++) step();
        chk_all("tc.wrap16", 0, 1, 1, 0, 0);
        for (int k = 1; k <= 4; k++) step();
        chk_all("tc.wrap17", 0, 1, 1, 0, 1);

        // Reset must have restored the custom divisor to 3.
        sel = 2'd3;
        for (int k = 1; k <= 4; k++) step();
        chk_all("m3rst.enter", 0, 1, 1, 3, 2);
        for (int k = 1; k <= 3; k++) begin
            step();
            chk_all("m3rst", k % 3, k == 3, (k % 3) < 2, 3, (k == 3) ? 3 : 2);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/multi_mode_tick_divider.md
Name: multi_mode_tick_divider

Overview:
- Parametrised successor to the fixed four-setting clock divider.
- Derives a one-cycle tick and a near-50% square wave from `clock`, using a divisor picked from three compile-time presets or one runtime-loadable custom divisor.
- Adds enable/freeze and glitch-free mode switching: a new mode takes effect only at a period boundary.
- Adds a running tick counter. Feeds LED/counter logic that currently counts divider pulses.

Parameters:
- WIDTH, 29, width of divisor and period counter.
- CNT_W, 16, width of tick_count.
- DIV0, 25000000, period in clocks for sel=0.
- DIV1, 50000000, period in clocks for sel=1.
- DIV2, 100000000, period in clocks for sel=2.
- DIV3_RST, 300000000, reset value of custom divisor register (sel=3).

Ports:
- clock  in  1  system clock, all logic on rising edge.
- reset_n  in  1  synchronous reset, active-low.
- enable  in  1  1 = count; 0 = freeze all state.
- sel  in  2  requested mode (0..2 presets, 3 custom).
- load  in  1  1-cycle strobe: custom_div <= div_in.
- div_in  in  WIDTH  new custom divisor.
- tick  out  1  high one cycle per period.
- square  out  1  square wave, period = active divisor.
- count  out  WIDTH  current period counter.
- active_sel  out  2  mode in effect for current period.
- tick_count  out  CNT_W  number of ticks since reset, wraps.

Behaviour:
- Reset (reset_n=0 at edge): count=0, tick=0, square=0, active_sel=0, cur_div=DIV0, custom_div=DIV3_RST, tick_count=0. Reset overrides all other inputs, including mid-period.
- cur_div is a snapshot register holding the divisor in effect. Divisor of mode m: DIV0/DIV1/DIV2/custom_div.
- Enabled cycle, cur_div>=1:
  - if count == cur_div-1: count<=0, tick<=1, tick_count<=tick_count+1 (mod 2^CNT_W), active_sel<=sel, cur_div<=divisor(sel);
  - else count<=count+1, tick<=0.
- Period is exactly cur_div clocks. tick is asserted in the cycle where count==0 after a wrap; it is not asserted at count==0 after reset.
- cur_div==1: tick high every enabled cycle, count stays 0.
- cur_div==0 (idle mode): count held 0, tick=0. active_sel<=sel and cur_div<=divisor(sel) every enabled cycle, so leaving idle needs no boundary.
- square is registered. On every cycle count updates, square <= (next count < (cur_div_next+1)>>1). It is high for the first ceil(N/2) clocks of each period; N=1 gives constant 1, N=0 gives 0.
- enable=0: count, square, active_sel, cur_div and tick_count hold; tick<=0. load still updates custom_div.
- sel changes mid-period: ignored until the next wrap. Multiple changes within a period: the value at the wrap cycle wins.
- load mid-period in mode 3: custom_div updates next cycle; cur_div is unaffected until the next wrap, so no truncated or overlong period.
- load in the same cycle as a wrap selecting mode 3: the wrap uses the old custom_div; the new value applies from the following boundary.
- Arithmetic: compare uses cur_div-1 in WIDTH bits; cur_div==0 is handled explicitly, never via underflow.

Test Plan:
- Bench params DIV0=4, DIV1=5, DIV2=8, DIV3_RST=3, sel=0, enable=1, release reset:
  - tick at cycles 4, 8, 12 after release;
  - square pattern 1,1,0,0 repeating;
  - tick_count=3 after cycle 12.
- sel 0->2 at count=1:
  - next tick still 4 cycles after the previous one;
  - then period 8 with square 1111 0000;
  - active_sel changes at the wrap cycle.
- sel=3, custom period 3:
  - square 1,1,0;
  - load div_in=6 at count=1: current period stays 3, next period 6;
  - load div_in=0: module idles after the boundary, tick=0;
  - then sel=1: period 5 begins on the next cycle.
- enable low for 10 cycles at count=2:
  - count, square and tick_count frozen, tick=0;
  - on re-enable the tick arrives after 2 more cycles (DIV0=4).
- reset_n=0 for one cycle at count=3 in mode 2: all outputs return to reset values; next tick 4 cycles later (mode 0).
- CNT_W=4: after 16 ticks tick_count wraps to 0; after 17 ticks it reads 1.
